micro_seq: RTL and testbench
============================

MICRO_SEQ -- requirements
Module: micro_seq

Interface
REQ-001 SHALL have parameter ROM_DEPTH, default 136, number of valid microcode words (addresses 0..ROM_DEPTH-1).
REQ-002 SHALL have parameter CTRL_W, default 16, width of control field (microword bits [31:16]).
REQ-003 SHALL use one clock and an asynchronous active-low reset:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin execution at address 0
- address  output  8  microcode ROM address (feeds ROM address input)
- data  input  32  microword from ROM, combinational from address
- cond  input  4  condition flags
- mem_ready  input  1  releases WAIT
- ir_valid  input  1  opcode available
- ir_opcode  input  8  instruction opcode
- ir_ready  output  1  opcode accepted, one-cycle pulse
- ctrl  output  CTRL_W  registered control word
- halted  output  1  sequencer in HALT
- fault  output  1  sticky fault flag

Function
REQ-004 SHALL decode each microword as: [31:16] ctrl, [15:13] op, [12:11] cond select, [10] cond invert, [9:8] reserved (ignored), [7:0] target.
REQ-005 SHALL use op encodings SEQ=0, JMP=1, CJMP=2, DISPATCH=3, CALL=4, RET=5, WAIT=6, HALT=7.
REQ-006 SHALL drive address from a registered micro-PC (upc) only.
REQ-007 SHALL implement states IDLE, RUN, STALL, DISP, HALT.
REQ-008 SHALL, in IDLE, hold upc=0 and ctrl=0, and enter RUN on start.
REQ-009 SHALL, on each RUN cycle, register data[31:16] into ctrl and load upc with the next address; ctrl therefore lags address by exactly one cycle.
REQ-010 SHALL compute the next address as:
- SEQ: upc+1
- JMP: target
- CJMP: target if cond[sel]^inv, else upc+1
- CALL: push upc+1, then target
- RET: pop
REQ-011 SHALL, on WAIT with mem_ready=1, behave as SEQ; with mem_ready=0, enter STALL, hold upc, and hold ctrl at the WAIT word's control field until mem_ready=1, then go to upc+1 in RUN.
REQ-012 SHALL, on DISPATCH with ir_valid=1, assert ir_ready for that cycle and load upc=target+ir_opcode[5:0]; with ir_valid=0, enter DISP, hold upc, and force ctrl=0 until ir_valid.
REQ-013 SHALL, on HALT, load ctrl from the HALT word, enter HALT, and assert halted; start in HALT restarts at upc=0, clears fault, and clears the stack.
REQ-014 SHALL ignore start in RUN, STALL and DISP.
REQ-015 SHALL treat any next address >= ROM_DEPTH (including upc+1 wrap from ROM_DEPTH-1, and dispatch sum overflow) as a fault: set fault, enter HALT, and leave upc unchanged.
REQ-016 SHALL never assert ir_ready outside a DISPATCH acceptance cycle.

Reset
REQ-017 SHALL, on rst_n low, asynchronously set state=IDLE, upc=0, ctrl=0, ir_ready=0, halted=0, fault=0, stack pointer=0, regardless of operation in progress.

Configuration
REQ-018 SHALL, with MICRO_SEQ_CALL_EN defined, implement a 4-entry return stack; CALL with 4 entries pushed, or RET with the stack empty, sets fault and enters HALT.
REQ-019 SHALL, without MICRO_SEQ_CALL_EN, include no stack logic; CALL executes as JMP and RET as SEQ.

Structure
REQ-020 SHALL take op encodings, field bit positions, state encoding and ROM_DEPTH default from shared package micro_pkg.
REQ-021 SHALL place the return stack in sub-module micro_stack (push, pop, data in/out, full, empty), instantiated only under MICRO_SEQ_CALL_EN.

Verification
REQ-022 Bench SHALL cover:
- ROM with SEQ at 0..2 and JMP 0x10 at 3; start -> address sequence 0,1,2,3,0x10; ctrl equals each word's [31:16] one cycle later.
- CJMP sel=2 inv=0 target 0x20 at 5 -> cond=4'b0100 gives 0x20; cond=0 gives 6.
- DISPATCH target 0x40 with ir_valid low 3 cycles, then opcode 0x05 -> ctrl=0 for 3 cycles, single ir_ready pulse, address 0x45.
- WAIT at 7 with mem_ready low 4 cycles -> address held at 7 for 4 cycles, then 8.
- SEQ at address 135 -> fault=1, halted=1; start -> address 0, fault=0.
- With MICRO_SEQ_CALL_EN: CALL 0x30 at 9, RET at 0x30 -> returns to 10; 5 nested CALLs -> fault. Also: rst_n low mid-STALL -> all outputs 0, state IDLE.

Source files
------------

// File: rtl/micro_pkg.sv
// -----------------------------------------------------------------------------
// micro_pkg
// Shared definitions for the micro_seq microcode sequencer:
//   - microword field bit positions
//   - op encodings (op_e) and sequencer state encoding (state_e)
//   - default ROM depth and return-stack depth
// No ports; imported by micro_seq and micro_stack.
// -----------------------------------------------------------------------------
package micro_pkg;

    // Number of valid microcode words by default (addresses 0..135)
    localparam int ROM_DEPTH_DEFAULT = 136;

    // Address widths: ADDR_W for the micro-PC, NEXT_W keeps one extra bit so
    // that upc+1 and dispatch sums can be range-checked without wrapping.
    localparam int ADDR_W = 8;
    localparam int NEXT_W = 9;

    // Return stack depth (only used when the CALL/RET feature is built)
    localparam int STACK_DEPTH = 4;

    // Microword field positions
    localparam int CTRL_HI = 31;
    localparam int CTRL_LO = 16;
    localparam int OP_HI   = 15;
    localparam int OP_LO   = 13;
    localparam int SEL_HI  = 12;
    localparam int SEL_LO  = 11;
    localparam int INV_BIT = 10;
    localparam int RSV_HI  = 9;
    localparam int RSV_LO  = 8;
    localparam int TGT_HI  = 7;
    localparam int TGT_LO  = 0;

    typedef enum logic [2:0] {
        OP_SEQ      = 3'd0,
        OP_JMP      = 3'd1,
        OP_CJMP     = 3'd2,
        OP_DISPATCH = 3'd3,
        OP_CALL     = 3'd4,
        OP_RET      = 3'd5,
        OP_WAIT     = 3'd6,
        OP_HALT     = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_STALL = 3'd2,
        ST_DISP  = 3'd3,
        ST_HALT  = 3'd4
    } state_e;

    // Extract the op field of a microword as a typed value
    function automatic op_e word_op(input logic [31:0] word);
        return op_e'(word[OP_HI:OP_LO]);
    endfunction

endpackage

// File: rtl/micro_stack.sv
// -----------------------------------------------------------------------------
// micro_stack
// Small LIFO return-address stack for micro_seq CALL/RET.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (empties the stack)
//   clr        : synchronous clear (empties the stack)
//   push, din  : push din when not full
//   pop        : discard top entry when not empty
//   dout       : current top entry (combinational, valid when !empty)
//   full/empty : occupancy flags
// -----------------------------------------------------------------------------
module micro_stack
    import micro_pkg::*;
#(
    parameter int DEPTH = STACK_DEPTH,
    parameter int W     = NEXT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int SPW = $clog2(DEPTH + 1);
    localparam int AW  = $clog2(DEPTH);

    logic [W-1:0]   mem_r [DEPTH];
    logic [SPW-1:0] sp_r;   // number of entries currently held

    assign full  = (sp_r == SPW'(DEPTH));
    assign empty = (sp_r == {SPW{1'b0}});
    assign dout  = mem_r[AW'(sp_r - SPW'(1))];

    // Stack storage and pointer; clear wins over push/pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_r <= {SPW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {W{1'b0}};
            end
        end else if (clr) begin
            sp_r <= {SPW{1'b0}};
        end else if (push && !full) begin
            mem_r[AW'(sp_r)] <= din;
            sp_r             <= sp_r + SPW'(1);
        end else if (pop && !empty) begin
            sp_r <= sp_r - SPW'(1);
        end else begin
            sp_r <= sp_r;
        end
    end

endmodule

// File: rtl/micro_seq.sv
// -----------------------------------------------------------------------------
// micro_seq
// Microcode sequencer: fetches 32-bit microwords from an external
// combinational ROM addressed by a registered micro-PC, registers the control
// field and computes the next address (SEQ/JMP/CJMP/DISPATCH/CALL/RET/WAIT/HALT).
// Any next address >= ROM_DEPTH raises a sticky fault and halts.
//
// Build option: define MICRO_SEQ_CALL_EN to get a 4-entry return stack
// (micro_stack). Without it, CALL behaves as JMP and RET as SEQ.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : begin execution at address 0 (IDLE/HALT only)
//   address[7:0]        : ROM address (the micro-PC)
//   data[31:0]          : microword at address
//   cond[3:0]           : condition flags for CJMP
//   mem_ready           : releases WAIT
//   ir_valid, ir_opcode : opcode handshake for DISPATCH
//   ir_ready            : one-cycle pulse when an opcode is accepted
//   ctrl[CTRL_W-1:0]    : registered control field
//   halted, fault       : in HALT / sticky fault
// -----------------------------------------------------------------------------
module micro_seq
    import micro_pkg::*;
#(
    parameter int ROM_DEPTH = ROM_DEPTH_DEFAULT,
    parameter int CTRL_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [7:0]        address,
    input  logic [31:0]       data,
    input  logic [3:0]        cond,
    input  logic              mem_ready,
    input  logic              ir_valid,
    input  logic [7:0]        ir_opcode,
    output logic              ir_ready,
    output logic [CTRL_W-1:0] ctrl,
    output logic              halted,
    output logic              fault
);

    localparam logic [NEXT_W-1:0] ROM_LIMIT = NEXT_W'(ROM_DEPTH);

    state_e              state_r;
    logic [ADDR_W-1:0]   upc_r;

    op_e                 op_s;
    logic [1:0]          sel_s;
    logic                inv_s;
    logic [7:0]          tgt_s;
    logic [CTRL_W-1:0]   ctrl_word_s;
    logic                cond_hit_s;
    logic [NEXT_W-1:0]   seq_addr_s;
    logic [NEXT_W-1:0]   tgt_addr_s;
    logic [NEXT_W-1:0]   disp_addr_s;
    logic [NEXT_W-1:0]   nxt_s;
    logic                range_fault_s;
    logic                stk_fault_s;
    logic                any_fault_s;
    logic                unused_s;

    assign address = upc_r;

    // Reserved microword bits and the upper opcode bits carry no meaning here
    assign unused_s = ^{data[RSV_HI:RSV_LO], ir_opcode[7:6]};

`ifdef MICRO_SEQ_CALL_EN
    logic              stk_push_s;
    logic              stk_pop_s;
    logic              stk_clr_s;
    logic              stk_full_s;
    logic              stk_empty_s;
    logic [NEXT_W-1:0] stk_top_s;

    micro_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (NEXT_W)
    ) u_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (stk_clr_s),
        .push  (stk_push_s),
        .pop   (stk_pop_s),
        .din   (seq_addr_s),
        .dout  (stk_top_s),
        .full  (stk_full_s),
        .empty (stk_empty_s)
    );

    // Stack control: only touch the stack on a RUN cycle that really advances
    always_comb begin
        stk_push_s = 1'b0;
        stk_pop_s  = 1'b0;
        stk_clr_s  = (state_r == ST_HALT) && start;
        if ((state_r == ST_RUN) && !any_fault_s) begin
            stk_push_s = (op_s == OP_CALL);
            stk_pop_s  = (op_s == OP_RET);
        end else begin
            stk_push_s = 1'b0;
            stk_pop_s  = 1'b0;
        end
    end
`endif

    // Decode the current microword and select the candidate next address.
    // Sums are NEXT_W wide so an overflow past 255 is still seen as out of range.
    always_comb begin
        op_s        = word_op(data);
        sel_s       = data[SEL_HI:SEL_LO];
        inv_s       = data[INV_BIT];
        tgt_s       = data[TGT_HI:TGT_LO];
        ctrl_word_s = CTRL_W'(data[CTRL_HI:CTRL_LO]);
        cond_hit_s  = cond[sel_s] ^ inv_s;
        seq_addr_s  = {1'b0, upc_r} + 9'd1;
        tgt_addr_s  = {1'b0, tgt_s};
        disp_addr_s = tgt_addr_s + {3'b000, ir_opcode[5:0]};
        nxt_s       = seq_addr_s;
        stk_fault_s = 1'b0;
        case (op_s)
            OP_SEQ:      nxt_s = seq_addr_s;
            OP_JMP:      nxt_s = tgt_addr_s;
            OP_CJMP: begin
                if (cond_hit_s) begin
                    nxt_s = tgt_addr_s;
                end else begin
                    nxt_s = seq_addr_s;
                end
            end
            OP_DISPATCH: nxt_s = disp_addr_s;
`ifdef MICRO_SEQ_CALL_EN
            OP_CALL: begin
                nxt_s       = tgt_addr_s;
                stk_fault_s = stk_full_s;
            end
            OP_RET: begin
                nxt_s       = stk_top_s;
                stk_fault_s = stk_empty_s;
            end
`else
            OP_CALL:     nxt_s = tgt_addr_s;
            OP_RET:      nxt_s = seq_addr_s;
`endif
            OP_WAIT:     nxt_s = seq_addr_s;
            OP_HALT:     nxt_s = {1'b0, upc_r};
            default:     nxt_s = seq_addr_s;
        endcase
        range_fault_s = (nxt_s >= ROM_LIMIT);
        any_fault_s   = range_fault_s || stk_fault_s;
    end

    // Sequencer FSM with all outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            upc_r    <= {ADDR_W{1'b0}};
            ctrl     <= {CTRL_W{1'b0}};
            ir_ready <= 1'b0;
            halted   <= 1'b0;
            fault    <= 1'b0;
        end else begin
            ir_ready <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    upc_r <= {ADDR_W{1'b0}};
                    ctrl  <= {CTRL_W{1'b0}};
                    if (start) begin
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end

                ST_RUN: begin
                    ctrl <= ctrl_word_s;
                    if (op_s == OP_HALT) begin
                        state_r <= ST_HALT;
                        halted  <= 1'b1;
                    end else if ((op_s == OP_WAIT) && !mem_ready) begin
                        state_r <= ST_STALL;
                    end else if ((op_s == OP_DISPATCH) && !ir_valid) begin
                        // No opcode yet: park with a neutral control word
                        state_r <= ST_DISP;
                        ctrl    <= {CTRL_W{1'b0}};
                    end else if (any_fault_s) begin
                        state_r <= ST_HALT;
                        halted  <= 1'b1;
                        fault   <= 1'b1;
                    end else begin
                        upc_r    <= nxt_s[ADDR_W-1:0];
                        ir_ready <= (op_s == OP_DISPATCH);
                    end
                end

                ST_STALL: begin
                    // upc and ctrl hold the WAIT word until memory is ready
                    if (!mem_ready) begin
                        state_r <= ST_STALL;
                    end else if (range_fault_s) begin
                        state_r <= ST_HALT;
                        halted  <= 1'b1;
                        fault   <= 1'b1;
                    end else begin
                        state_r <= ST_RUN;
                        upc_r   <= seq_addr_s[ADDR_W-1:0];
                    end
                end

                ST_DISP: begin
                    if (!ir_valid) begin
                        ctrl    <= {CTRL_W{1'b0}};
                        state_r <= ST_DISP;
                    end else if (range_fault_s) begin
                        ctrl    <= ctrl_word_s;
                        state_r <= ST_HALT;
                        halted  <= 1'b1;
                        fault   <= 1'b1;
                    end else begin
                        ctrl     <= ctrl_word_s;
                        upc_r    <= disp_addr_s[ADDR_W-1:0];
                        ir_ready <= 1'b1;
                        state_r  <= ST_RUN;
                    end
                end

                ST_HALT: begin
                    if (start) begin
                        state_r <= ST_RUN;
                        upc_r   <= {ADDR_W{1'b0}};
                        halted  <= 1'b0;
                        fault   <= 1'b0;
                    end else begin
                        state_r <= ST_HALT;
                    end
                end

                default: begin
                    state_r <= ST_IDLE;
                    upc_r   <= {ADDR_W{1'b0}};
                    ctrl    <= {CTRL_W{1'b0}};
                    halted  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_micro_seq.sv
// -----------------------------------------------------------------------------
// tb_micro_seq
// Self-checking bench for micro_seq: a microcode ROM image is held in the
// bench, per-cycle stimulus/expectation records are driven from a table and
// checked through a scoreboard queue, and reset-in-STALL is a hand sequence.
// CALL/RET vectors are added when MICRO_SEQ_CALL_EN is defined.
// -----------------------------------------------------------------------------
module tb_micro_seq;
    import micro_pkg::*;

    localparam logic [2:0] E_SEQ  = 3'd0;
    localparam logic [2:0] E_JMP  = 3'd1;
    localparam logic [2:0] E_CJMP = 3'd2;
    localparam logic [2:0] E_DISP = 3'd3;
    localparam logic [2:0] E_CALL = 3'd4;
    localparam logic [2:0] E_RET  = 3'd5;
    localparam logic [2:0] E_WAIT = 3'd6;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  address;
    logic [31:0] data;
    logic [3:0]  cond;
    logic        mem_ready;
    logic        ir_valid;
    logic [7:0]  ir_opcode;
    logic        ir_ready;
    logic [15:0] ctrl;
    logic        halted;
    logic        fault;

    logic [31:0] rom [256];
    assign data = rom[address];

    micro_seq #(.ROM_DEPTH(136), .CTRL_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .address   (address),
        .data      (data),
        .cond      (cond),
        .mem_ready (mem_ready),
        .ir_valid  (ir_valid),
        .ir_opcode (ir_opcode),
        .ir_ready  (ir_ready),
        .ctrl      (ctrl),
        .halted    (halted),
        .fault     (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic [3:0]  cond;
        logic        mem_ready;
        logic        ir_valid;
        logic [7:0]  opc;
        logic [7:0]  e_addr;
        logic [15:0] e_ctrl;
        logic        chk_ctrl;
        logic        e_ir_ready;
        logic        e_halted;
        logic        e_fault;
    } vec_t;

    vec_t vecs[$];
    vec_t sb_q[$];

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Microword encoder; reserved bits are set to show they are ignored
    function automatic logic [31:0] mw(input logic [15:0] c, input logic [2:0] op,
                                       input logic [7:0] tgt, input logic [1:0] sel,
                                       input logic inv);
        return {c, op, sel, inv, 2'b11, tgt};
    endfunction

    function automatic void add(input logic st, input logic [3:0] cd, input logic mr,
                                input logic iv, input logic [7:0] opc,
                                input logic [7:0] ea, input logic [15:0] ec, input logic cc,
                                input logic er, input logic eh, input logic ef);
        vec_t v;
        v.start = st; v.cond = cd; v.mem_ready = mr; v.ir_valid = iv; v.opc = opc;
        v.e_addr = ea; v.e_ctrl = ec; v.chk_ctrl = cc;
        v.e_ir_ready = er; v.e_halted = eh; v.e_fault = ef;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    // Apply queued vectors at the falling edge, score after the next rising edge
    task automatic run_vectors(input string tag);
        vec_t e;
        for (int i = 0; i < vecs.size(); i++) begin
            start     = vecs[i].start;
            cond      = vecs[i].cond;
            mem_ready = vecs[i].mem_ready;
            ir_valid  = vecs[i].ir_valid;
            ir_opcode = vecs[i].opc;
            sb_q.push_back(vecs[i]);
            @(posedge clk);
            @(negedge clk);
            e = sb_q.pop_front();
            chk($sformatf("%s[%0d].address", tag, i), 32'(address), 32'(e.e_addr));
            if (e.chk_ctrl) begin
                chk($sformatf("%s[%0d].ctrl", tag, i), 32'(ctrl), 32'(e.e_ctrl));
            end
            chk($sformatf("%s[%0d].ir_ready", tag, i), 32'(ir_ready), 32'(e.e_ir_ready));
            chk($sformatf("%s[%0d].halted", tag, i), 32'(halted), 32'(e.e_halted));
            chk($sformatf("%s[%0d].fault", tag, i), 32'(fault), 32'(e.e_fault));
        end
        vecs.delete();
        start = 1'b0;
    endtask

    initial begin
        logic found;

        rst_n = 1'b0; start = 1'b0; cond = 4'd0; mem_ready = 1'b1;
        ir_valid = 1'b0; ir_opcode = 8'd0;

        for (int i = 0; i < 256; i++) rom[i] = 32'h0000_0000;
        rom[8'h00] = mw(16'h1000, E_SEQ,  8'h00, 2'd0, 1'b0);
        rom[8'h01] = mw(16'h1001, E_SEQ,  8'h00, 2'd0, 1'b0);
        rom[8'h02] = mw(16'h1002, E_SEQ,  8'h00, 2'd0, 1'b0);
        rom[8'h03] = mw(16'h1003, E_JMP,  8'h10, 2'd0, 1'b0);
        rom[8'h10] = mw(16'h1010, E_JMP,  8'h05, 2'd0, 1'b0);
        rom[8'h05] = mw(16'h1005, E_CJMP, 8'h20, 2'd2, 1'b0);
        rom[8'h20] = mw(16'h1020, E_JMP,  8'h05, 2'd0, 1'b0);
        rom[8'h06] = mw(16'h1006, E_DISP, 8'h40, 2'd0, 1'b0);
        rom[8'h45] = mw(16'h1045, E_JMP,  8'h07, 2'd0, 1'b0);
        rom[8'h07] = mw(16'h1007, E_WAIT, 8'h00, 2'd0, 1'b0);
        rom[8'h08] = mw(16'h1008, E_JMP,  8'h86, 2'd0, 1'b0);
        rom[8'h86] = mw(16'h1086, E_SEQ,  8'h00, 2'd0, 1'b0);
        rom[8'h87] = mw(16'h1087, E_SEQ,  8'h00, 2'd0, 1'b0);
        rom[8'h09] = mw(16'h2009, E_CALL, 8'h30, 2'd0, 1'b0);
        rom[8'h30] = mw(16'h2030, E_RET,  8'h00, 2'd0, 1'b0);
        rom[8'h0A] = mw(16'h200A, E_JMP,  8'h50, 2'd0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            rom[8'h50 + k] = mw(16'h2050 + 16'(k), E_CALL, 8'h51 + 8'(k), 2'd0, 1'b0);
        end

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst.address", 32'(address), 32'h0);
        chk("rst.ctrl", 32'(ctrl), 32'h0);
        chk("rst.ir_ready", 32'(ir_ready), 32'h0);
        chk("rst.halted", 32'(halted), 32'h0);
        chk("rst.fault", 32'(fault), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle.address", 32'(address), 32'h0);
        chk("idle.ctrl", 32'(ctrl), 32'h0);

        //  st  cond   mr  iv  opc    addr   ctrl      cc  irr hlt flt
        add(1, 4'h0, 1, 0, 8'h00, 8'h00, 16'h0000, 1, 0, 0, 0);
        add(0, 4'h0, 1, 0, 8'h00, 8'h01, 16'h1000, 1, 0, 0, 0);
        add(1, 4'h0, 1, 0, 8'h00, 8'h02, 16'h1001, 1, 0, 0, 0); // start ignored in RUN
        add(0, 4'h0, 1, 0, 8'h00, 8'h03, 16'h1002, 1, 0, 0, 0);
        add(0, 4'h0, 1, 0, 8'h00, 8'h10, 16'h1003, 1, 0, 0, 0);
        add(0, 4'h0, 1, 0, 8'h00, 8'h05, 16'h1010, 1, 0, 0, 0);
        add(0, 4'h4, 1, 0, 8'h00, 8'h20, 16'h1005, 1, 0, 0, 0); // CJMP taken
        add(0, 4'h0, 1, 0, 8'h00, 8'h05, 16'h1020, 1, 0, 0, 0);
        add(0, 4'hB, 1, 0, 8'h00, 8'h06, 16'h1005, 1, 0, 0, 0); // cond[2]=0: falls through
        add(0, 4'h0, 1, 0, 8'h00, 8'h06, 16'h0000, 1, 0, 0, 0); // DISPATCH, no opcode
        add(0, 4'h0, 1, 0, 8'h00, 8'h06, 16'h0000, 1, 0, 0, 0);
        add(1, 4'h0, 1, 0, 8'h00, 8'h06, 16'h0000, 1, 0, 0, 0); // start ignored in DISP
        add(0, 4'h0, 1, 1, 8'h05, 8'h45, 16'h0000, 0, 1, 0, 0); // opcode accepted
        add(0, 4'h0, 1, 0, 8'h00, 8'h07, 16'h1045, 1, 0, 0, 0);
        add(0, 4'h0, 0, 0, 8'h00, 8'h07, 16'h1007, 1, 0, 0, 0); // WAIT, not ready
        add(0, 4'h0, 0, 0, 8'h00, 8'h07, 16'h1007, 1, 0, 0, 0);
        add(1, 4'h0, 0, 0, 8'h00, 8'h07, 16'h1007, 1, 0, 0, 0); // start ignored in STALL
        add(0, 4'h0, 0, 0, 8'h00, 8'h07, 16'h1007, 1, 0, 0, 0);
        add(0, 4'h0, 1, 0, 8'h00, 8'h08, 16'h1007, 1, 0, 0, 0);
        add(0, 4'h0, 1, 0, 8'h00, 8'h86, 16'h1008, 1, 0, 0, 0);
        add(0, 4'h0, 1, 0, 8'h00, 8'h87, 16'h1086, 1, 0, 0, 0);
        add(0, 4'h0, 1, 0, 8'h00, 8'h87, 16'h1087, 1, 0, 1, 1); // 135+1 out of range
        add(0, 4'h0, 1, 0, 8'h00, 8'h87, 16'h1087, 1, 0, 1, 1);
        add(1, 4'h0, 1, 0, 8'h00, 8'h00, 16'h0000, 0, 0, 0, 0); // restart from HALT
        add(0, 4'h0, 1, 0, 8'h00, 8'h01, 16'h1000, 1, 0, 0, 0);
        run_vectors("main");

        // Walk to the WAIT word, stall there, then reset asynchronously
        found = 1'b0;
        cond = 4'h0; mem_ready = 1'b1; ir_valid = 1'b1; ir_opcode = 8'h05;
        for (int i = 0; i < 50 && !found; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (address == 8'h07) found = 1'b1;
        end
        chk("reach_wait", 32'(found), 32'h1);
        mem_ready = 1'b0; ir_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("stall.address", 32'(address), 32'h07);
        chk("stall.ctrl", 32'(ctrl), 32'h1007);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_stall.address", 32'(address), 32'h0);
        chk("rst_stall.ctrl", 32'(ctrl), 32'h0);
        chk("rst_stall.ir_ready", 32'(ir_ready), 32'h0);
        chk("rst_stall.halted", 32'(halted), 32'h0);
        chk("rst_stall.fault", 32'(fault), 32'h0);
        chk("rst_stall.state", 32'(dut.state_r), 32'(ST_IDLE));
        @(negedge clk);
        rst_n = 1'b1; mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst.address", 32'(address), 32'h0);
        chk("post_rst.state", 32'(dut.state_r), 32'(ST_IDLE));

`ifdef MICRO_SEQ_CALL_EN
        rom[8'h00] = mw(16'h2000, E_JMP, 8'h09, 2'd0, 1'b0);
        //  st  cond   mr  iv  opc    addr   ctrl      cc  irr hlt flt
        add(1, 4'h0, 1, 0, 8'h00, 8'h00, 16'h0000, 1, 0, 0, 0);
        add(0, 4'h0, 1, 0, 8'h00, 8'h09, 16'h2000, 1, 0, 0, 0);
        add(0, 4'h0, 1, 0, 8'h00, 8'h30, 16'h2009, 1, 0, 0, 0); // CALL 0x30
        add(0, 4'h0, 1, 0, 8'h00, 8'h0A, 16'h2030, 1, 0, 0, 0); // RET to 10
        add(0, 4'h0, 1, 0, 8'h00, 8'h50, 16'h200A, 1, 0, 0, 0);
        add(0, 4'h0, 1, 0, 8'h00, 8'h51, 16'h2050, 1, 0, 0, 0);
        add(0, 4'h0, 1, 0, 8'h00, 8'h52, 16'h2051, 1, 0, 0, 0);
        add(0, 4'h0, 1, 0, 8'h00, 8'h53, 16'h2052, 1, 0, 0, 0);
        add(0, 4'h0, 1, 0, 8'h00, 8'h54, 16'h2053, 1, 0, 0, 0);
        add(0, 4'h0, 1, 0, 8'h00, 8'h54, 16'h2054, 1, 0, 1, 1); // fifth CALL overflows
        run_vectors("call");
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
